dmem_copy_engine: RTL and testbench

- Initiator-side engine for the single-port data memory (combinational read, write on clock edge when WE is high).
- Drives the memory's read address, write address, write data and write enable to perform block copy or block fill of word-addressed regions without CPU involvement.
- Copy is overlap-safe (memmove semantics).
- Sits beside the CPU's load/store path; a top-level mux grants the memory ports to this engine while busy is high.

---
 rtl/dmem_copy_engine_if.sv | 39 +++
 rtl/dmem_copy_engine.sv | 140 ++++++++++++++
 tb/tb_dmem_copy_engine.sv | 239 +++++++++++++++++++++++
 3 files changed

// File: rtl/dmem_copy_engine_if.sv
// dmem_copy_engine_if: command, status and memory-port bundle for the data
// memory copy/fill engine.
//   master modport : the engine (takes commands and read data, drives the
//                    memory address/data/WE and the status outputs)
//   slave modport  : the environment (CPU-side command source plus the
//                    single-port data memory)
interface dmem_copy_engine_if #(
  parameter int ADDR_W = 15,
  parameter int DATA_W = 32
);
  logic              start;
  logic              mode;
  logic [ADDR_W-1:0] src_addr;
  logic [ADDR_W-1:0] dst_addr;
  logic [ADDR_W-1:0] len;
  logic [DATA_W-1:0] fill_value;
  logic              abort;
  logic [ADDR_W-1:0] mem_read_addr;
  logic [DATA_W-1:0] mem_read_data;
  logic [ADDR_W-1:0] mem_write_addr;
  logic [DATA_W-1:0] mem_write_data;
  logic              mem_we;
  logic              busy;
  logic              done;
  logic              aborted;
  logic [ADDR_W-1:0] words_done;

  modport master (
    input  start, mode, src_addr, dst_addr, len, fill_value, abort, mem_read_data,
    output mem_read_addr, mem_write_addr, mem_write_data, mem_we,
           busy, done, aborted, words_done
  );

  modport slave (
    output start, mode, src_addr, dst_addr, len, fill_value, abort, mem_read_data,
    input  mem_read_addr, mem_write_addr, mem_write_data, mem_we,
           busy, done, aborted, words_done
  );
endinterface

// File: rtl/dmem_copy_engine.sv
// dmem_copy_engine: block copy (memmove semantics) / block fill engine for the
// single-port data memory (combinational read, write on clock edge with WE).
//   clk, rst_n : clock, asynchronous active-low reset
//   bus        : command inputs (start, mode, src_addr, dst_addr, len,
//                fill_value, abort), memory port (mem_read_addr,
//                mem_read_data, mem_write_addr, mem_write_data, mem_we) and
//                status (busy, done, aborted, words_done)
// Copy costs 2 cycles/word (READ then WRITE), fill 1 cycle/word.
module dmem_copy_engine #(
  parameter int ADDR_W = 15,
  parameter int DATA_W = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  dmem_copy_engine_if.master bus
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_READ,
    S_WRITE,
    S_DONE
  } state_t;

  localparam logic [ADDR_W-1:0] ONE = ADDR_W'(1);

  state_t            state_q, state_d;
  logic              fill_q, fill_d;        // latched mode: 1 = fill
  logic              bwd_q, bwd_d;          // pointers step downward
  logic [DATA_W-1:0] fillv_q, fillv_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic [ADDR_W-1:0] src_q, src_d;
  logic [ADDR_W-1:0] dst_q, dst_d;
  logic [ADDR_W-1:0] rem_q, rem_d;
  logic [ADDR_W-1:0] wd_q, wd_d;
  logic              aborted_q, aborted_d;

  logic [ADDR_W-1:0] diff;
  logic              go_bwd;
  logic [ADDR_W-1:0] step;

  // Destination lies inside the source window (above src): a forward run
  // would overwrite source words before reading them, so copy top-down.
  assign diff   = bus.dst_addr - bus.src_addr;
  assign go_bwd = !bus.mode && (diff != '0) && (diff < bus.len);
  assign step   = bwd_q ? '1 : ONE;

  always_comb begin
    state_d   = state_q;
    fill_d    = fill_q;
    bwd_d     = bwd_q;
    fillv_d   = fillv_q;
    data_d    = data_q;
    src_d     = src_q;
    dst_d     = dst_q;
    rem_d     = rem_q;
    wd_d      = wd_q;
    aborted_d = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          if (bus.len == '0) begin
            state_d = S_DONE;
          end else begin
            fill_d  = bus.mode;
            fillv_d = bus.fill_value;
            rem_d   = bus.len;
            wd_d    = '0;
            bwd_d   = go_bwd;
            src_d   = go_bwd ? bus.src_addr + bus.len - ONE : bus.src_addr;
            dst_d   = go_bwd ? bus.dst_addr + bus.len - ONE : bus.dst_addr;
            state_d = bus.mode ? S_WRITE : S_READ;
          end
        end
      end
      S_READ: begin
        if (bus.abort) begin
          state_d   = S_IDLE;
          aborted_d = 1'b1;
        end else begin
          data_d  = bus.mem_read_data;
          state_d = S_WRITE;
        end
      end
      S_WRITE: begin
        if (bus.abort) begin
          state_d   = S_IDLE;
          aborted_d = 1'b1;
        end else begin
          src_d = src_q + step;
          dst_d = dst_q + step;
          rem_d = rem_q - ONE;
          wd_d  = wd_q + ONE;
          if (rem_q == ONE) state_d = S_DONE;
          else              state_d = fill_q ? S_WRITE : S_READ;
        end
      end
      S_DONE: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      fill_q    <= 1'b0;
      bwd_q     <= 1'b0;
      fillv_q   <= '0;
      data_q    <= '0;
      src_q     <= '0;
      dst_q     <= '0;
      rem_q     <= '0;
      wd_q      <= '0;
      aborted_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      fill_q    <= fill_d;
      bwd_q     <= bwd_d;
      fillv_q   <= fillv_d;
      data_q    <= data_d;
      src_q     <= src_d;
      dst_q     <= dst_d;
      rem_q     <= rem_d;
      wd_q      <= wd_d;
      aborted_q <= aborted_d;
    end
  end

  // abort gates WE in the same cycle so the aborted word is never written.
  assign bus.mem_we         = (state_q == S_WRITE) && !bus.abort;
  assign bus.mem_read_addr  = src_q;
  assign bus.mem_write_addr = dst_q;
  assign bus.mem_write_data = fill_q ? fillv_q : data_q;
  assign bus.busy           = (state_q != S_IDLE);
  assign bus.done           = (state_q == S_DONE);
  assign bus.aborted        = aborted_q;
  assign bus.words_done     = wd_q;

endmodule

// File: tb/tb_dmem_copy_engine.sv
module tb_dmem_copy_engine;
  localparam int AW = 15;
  localparam int DW = 32;
  localparam int MW = 1 << AW;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  dmem_copy_engine_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();
  dmem_copy_engine #(.ADDR_W(AW), .DATA_W(DW)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  // Environment memory driven by the engine, and the reference image.
  logic [DW-1:0] mem     [MW];
  logic [DW-1:0] ref_mem [MW];
  int            wr_cnt = 0;
  logic [AW-1:0] wr_addr_q[$];
  longint        wr_time_q[$];

  assign bus.mem_read_data = mem[bus.mem_read_addr];

  always @(posedge clk) begin
    if (bus.mem_we) begin
      mem[bus.mem_write_addr] <= bus.mem_write_data;
      wr_cnt = wr_cnt + 1;
      wr_addr_q.push_back(bus.mem_write_addr);
      wr_time_q.push_back($time);
    end
  end

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic int mem_mismatch();
    int n = 0;
    for (int i = 0; i < MW; i++) if (mem[i] !== ref_mem[i]) n++;
    return n;
  endfunction

  task automatic ref_copy(input logic [AW-1:0] s, input logic [AW-1:0] d, input int l);
    logic [DW-1:0] tmp[$];
    for (int i = 0; i < l; i++) tmp.push_back(ref_mem[AW'(s + i)]);
    for (int i = 0; i < l; i++) ref_mem[AW'(d + i)] = tmp[i];
  endtask

  task automatic ref_fill(input logic [AW-1:0] d, input int l, input logic [DW-1:0] v);
    for (int i = 0; i < l; i++) ref_mem[AW'(d + i)] = v;
  endtask

  task automatic poke(input int a, input logic [DW-1:0] v);
    mem[a]     = v;
    ref_mem[a] = v;
  endtask

  task automatic scramble_inputs();
    bus.mode       = 1'($urandom);
    bus.src_addr   = AW'($urandom);
    bus.dst_addr   = AW'($urandom);
    bus.len        = AW'($urandom);
    bus.fill_value = $urandom;
  endtask

  // Issues one command and follows it to completion. lat = cycle index of the
  // done pulse counted from the start edge (-1 if none). abort_nth/rst_nth
  // (0 = off) interrupt the run during that WRITE cycle.
  task automatic run_op(input bit m, input logic [AW-1:0] s, input logic [AW-1:0] d,
                        input int l, input logic [DW-1:0] fv, input bit restart,
                        input int abort_nth, input int rst_nth,
                        output int lat, output int nwr);
    int w0;
    int extra;
    lat = -1;
    @(negedge clk);
    bus.mode = m; bus.src_addr = s; bus.dst_addr = d; bus.len = AW'(l);
    bus.fill_value = fv; bus.start = 1'b1;
    w0 = wr_cnt;
    wr_addr_q.delete();
    wr_time_q.delete();
    for (int k = 1; k <= 2 * l + 8; k++) begin
      @(negedge clk);
      bus.start = 1'b0;
      scramble_inputs();
      if (restart && k == 3) bus.start = 1'b1;
      if (bus.done) begin
        lat = k;
        if (l != 0) check_eq("words_done_at_done", 64'(bus.words_done), 64'(l));
        break;
      end
      if (!bus.busy) break;
      if (abort_nth != 0 && bus.mem_we && (wr_cnt - w0) == abort_nth - 1) begin
        bus.abort = 1'b1;
        #1 check_eq("abort_gates_we", 64'(bus.mem_we), 64'd0);
        @(negedge clk);
        bus.abort = 1'b0;
        check_eq("aborted_pulse", 64'(bus.aborted), 64'd1);
        check_eq("abort_busy", 64'(bus.busy), 64'd0);
        check_eq("abort_no_done", 64'(bus.done), 64'd0);
        check_eq("abort_words_done", 64'(bus.words_done), 64'(abort_nth - 1));
        @(negedge clk);
        check_eq("aborted_one_cycle", 64'(bus.aborted), 64'd0);
        break;
      end
      if (rst_nth != 0 && bus.mem_we && (wr_cnt - w0) == rst_nth - 1) begin
        rst_n = 1'b0;
        #1;
        check_eq("rst_flags", 64'({bus.mem_we, bus.busy, bus.done, bus.aborted}), 64'd0);
        check_eq("rst_regs", 64'({bus.words_done, bus.mem_read_addr, bus.mem_write_addr}), 64'd0);
        check_eq("rst_wdata", 64'(bus.mem_write_data), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        break;
      end
    end
    if (lat > 0) begin
      @(negedge clk);
      check_eq("idle_after_done", 64'({bus.busy, bus.done}), 64'd0);
      if (restart) begin
        extra = 0;
        for (int k = 0; k < 2 * l + 4; k++) begin
          @(negedge clk);
          if (bus.done || bus.busy) extra++;
        end
        check_eq("single_done", 64'(extra), 64'd0);
      end
    end
    nwr = wr_cnt - w0;
  endtask

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat, nwr;
    bit m;
    logic [AW-1:0] s, d;
    logic [AW-1:0] dif;
    int l, exp_first;
    logic [DW-1:0] fv;

    bus.start = 1'b0; bus.abort = 1'b0;
    scramble_inputs();
    for (int i = 0; i < MW; i++) poke(i, $urandom);

    // Reset state
    repeat (3) @(negedge clk);
    check_eq("reset_flags", 64'({bus.mem_we, bus.busy, bus.done, bus.aborted}), 64'd0);
    check_eq("reset_regs", 64'({bus.words_done, bus.mem_read_addr, bus.mem_write_addr}), 64'd0);
    check_eq("reset_wdata", 64'(bus.mem_write_data), 64'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // Reset on the 3rd WRITE of an 8-word fill
    run_op(1'b1, 15'd0, 15'd100, 8, 32'h5a5a_1234, 1'b0, 0, 3, lat, nwr);
    check_eq("rst_fill_writes", 64'(nwr), 64'd2);
    ref_fill(15'd100, 2, 32'h5a5a_1234);
    check_eq("rst_fill_mem", 64'(mem_mismatch()), 64'd0);

    // Forward copy, no overlap
    poke(0, 32'habc); poke(1, 32'hbcd); poke(2, 32'hb); poke(3, 32'hc);
    run_op(1'b0, 15'd0, 15'd16, 4, 32'h0, 1'b0, 0, 0, lat, nwr);
    ref_copy(15'd0, 15'd16, 4);
    check_eq("fwd_latency", 64'(lat), 64'd9);
    check_eq("fwd_w16", 64'(mem[16]), 64'habc);
    check_eq("fwd_w19", 64'(mem[19]), 64'hc);
    check_eq("fwd_mem", 64'(mem_mismatch()), 64'd0);

    // Overlapping copies in both directions
    for (int i = 0; i < 4; i++) poke(i, DW'(i + 1));
    run_op(1'b0, 15'd0, 15'd2, 4, 32'h0, 1'b0, 0, 0, lat, nwr);
    ref_copy(15'd0, 15'd2, 4);
    check_eq("ovl_bwd_first", 64'(wr_addr_q[0]), 64'd5);
    check_eq("ovl_bwd_w5", 64'(mem[5]), 64'd4);
    check_eq("ovl_bwd_mem", 64'(mem_mismatch()), 64'd0);
    run_op(1'b0, 15'd2, 15'd0, 4, 32'h0, 1'b0, 0, 0, lat, nwr);
    ref_copy(15'd2, 15'd0, 4);
    check_eq("ovl_fwd_first", 64'(wr_addr_q[0]), 64'd0);
    check_eq("ovl_fwd_w3", 64'(mem[3]), 64'd4);
    check_eq("ovl_fwd_mem", 64'(mem_mismatch()), 64'd0);

    // Fill across the address wrap
    run_op(1'b1, 15'd0, 15'd32766, 4, 32'hdead_beef, 1'b0, 0, 0, lat, nwr);
    ref_fill(15'd32766, 4, 32'hdead_beef);
    check_eq("wrap_latency", 64'(lat), 64'd5);
    check_eq("wrap_addrs", 64'({wr_addr_q[0], wr_addr_q[1], wr_addr_q[2], wr_addr_q[3]}),
             64'({15'd32766, 15'd32767, 15'd0, 15'd1}));
    check_eq("wrap_back_to_back", 64'(wr_time_q[3] - wr_time_q[0]), 64'd30);
    check_eq("wrap_mem", 64'(mem_mismatch()), 64'd0);

    // Zero length
    run_op(1'b0, 15'd40, 15'd50, 0, 32'h0, 1'b0, 0, 0, lat, nwr);
    check_eq("zero_latency", 64'(lat), 64'd1);
    check_eq("zero_writes", 64'(nwr), 64'd0);

    // Abort during the 4th WRITE of a 10-word copy
    run_op(1'b0, 15'd200, 15'd300, 10, 32'h0, 1'b0, 4, 0, lat, nwr);
    ref_copy(15'd200, 15'd300, 3);
    check_eq("abort_writes", 64'(nwr), 64'd3);
    check_eq("abort_mem", 64'(mem_mismatch()), 64'd0);
    check_eq("abort_wd_hold", 64'(bus.words_done), 64'd3);

    // Start while busy is ignored
    run_op(1'b0, 15'd400, 15'd500, 6, 32'h0, 1'b1, 0, 0, lat, nwr);
    ref_copy(15'd400, 15'd500, 6);
    check_eq("restart_latency", 64'(lat), 64'd13);
    check_eq("restart_mem", 64'(mem_mismatch()), 64'd0);

    // Randomized operations against the memmove/fill reference
    for (int t = 0; t < 24; t++) begin
      m  = 1'($urandom);
      s  = AW'($urandom);
      d  = ($urandom_range(0, 2) != 0) ? AW'(s + AW'($urandom_range(0, 30)) - 15'd15) : AW'($urandom);
      l  = $urandom_range(1, 24);
      fv = $urandom;
      run_op(m, s, d, l, fv, 1'b0, 0, 0, lat, nwr);
      if (m) ref_fill(d, l, fv);
      else   ref_copy(s, d, l);
      dif = d - s;
      exp_first = (!m && dif != 0 && int'(dif) < l) ? int'(AW'(d + AW'(l - 1))) : int'(d);
      check_eq("rnd_latency", 64'(lat), m ? 64'(l + 1) : 64'(2 * l + 1));
      check_eq("rnd_writes", 64'(nwr), 64'(l));
      check_eq("rnd_first_addr", 64'(wr_addr_q.size() > 0 ? int'(wr_addr_q[0]) : -1), 64'(exp_first));
      check_eq("rnd_mem", 64'(mem_mismatch()), 64'd0);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
